// File: rtl/packet_assembler_if.sv
// Word-in / frame-out bus for the packet assembler.
// The master drives received words; the slave (the assembler) returns
// completed frames plus busy and error status.
interface packet_assembler_if #(
  parameter int WORD_WIDTH  = 8,
  parameter int VALUE_WORDS = 4
);
  logic [WORD_WIDTH-1:0]                 i_word;
  logic                                  i_word_dv;
  logic [(VALUE_WORDS+2)*WORD_WIDTH-1:0] o_data;
  logic                                  o_dv;
  logic                                  o_busy;
  logic                                  o_err;

  modport master (
    output i_word, i_word_dv,
    input  o_data, o_dv, o_busy, o_err
  );

  modport slave (
    input  i_word, i_word_dv,
    output o_data, o_dv, o_busy, o_err
  );
endinterface

// File: rtl/packet_assembler.sv
// Packet assembler: hunts for a command word ('r' or 'w'), then collects
// an address word and VALUE_WORDS value words into one frame. A frame that
// stalls for TIMEOUT_CYCLES idle cycles is discarded with an error pulse.
module packet_assembler #(
  parameter int WORD_WIDTH     = 8,
  parameter int VALUE_WORDS    = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input logic               clk,
  input logic               i_reset,
  packet_assembler_if.slave bus
);

  localparam int FRAME_WORDS = VALUE_WORDS + 2;
  localparam int DATA_W      = FRAME_WORDS * WORD_WIDTH;
  localparam int SHIFT_W     = (FRAME_WORDS - 1) * WORD_WIDTH;
  localparam int CNT_W       = $clog2(FRAME_WORDS + 1);
  localparam int GAP_W       = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [WORD_WIDTH-1:0] CMD_READ  = WORD_WIDTH'(8'h72);
  localparam logic [WORD_WIDTH-1:0] CMD_WRITE = WORD_WIDTH'(8'h77);

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [CNT_W-1:0]   r_count;
  logic [GAP_W-1:0]   r_gap;
  logic [SHIFT_W-1:0] r_shift;
  logic [DATA_W-1:0]  r_data;
  logic               r_dv;
  logic               r_busy;
  logic               r_err;

  logic w_loadCmd;
  logic w_shiftWord;
  logic w_complete;
  logic w_badCmd;
  logic w_timeout;

  // The final word never lands in the shift register; it is appended
  // directly when the frame is copied out, so the register holds one word less.

  // State register
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) r_state <= HUNT;
    else         r_state <= w_nextState;
  end

  // Next-state decode and per-cycle datapath actions
  always_comb begin
    w_nextState = r_state;
    w_loadCmd   = 1'b0;
    w_shiftWord = 1'b0;
    w_complete  = 1'b0;
    w_badCmd    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      HUNT: begin
        if (bus.i_word_dv) begin
          if (bus.i_word == CMD_READ || bus.i_word == CMD_WRITE) begin
            w_loadCmd   = 1'b1;
            w_nextState = COLLECT;
          end else begin
            w_badCmd = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (bus.i_word_dv) begin
          if (r_count == CNT_W'(FRAME_WORDS - 1)) begin
            w_complete  = 1'b1;
            w_nextState = HUNT;
          end else begin
            w_shiftWord = 1'b1;
          end
        end else if (r_gap >= GAP_W'(TIMEOUT_CYCLES - 1)) begin
          w_timeout   = 1'b1;
          w_nextState = HUNT;
        end
      end
      default: w_nextState = HUNT;
    endcase
  end

  // Frame collection, output register and one-cycle status pulses
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_shift <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_dv    <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_dv   <= w_complete;
      r_err  <= w_badCmd | w_timeout;
      r_busy <= (w_nextState == COLLECT);
      if (w_loadCmd) begin
        r_shift <= {{(SHIFT_W-WORD_WIDTH){1'b0}}, bus.i_word};
        r_count <= CNT_W'(1);
      end else if (w_shiftWord) begin
        r_shift <= {r_shift[SHIFT_W-WORD_WIDTH-1:0], bus.i_word};
        r_count <= r_count + CNT_W'(1);
      end else if (w_complete) begin
        r_data  <= {r_shift, bus.i_word};
        r_shift <= '0;
        r_count <= '0;
      end else if (w_timeout) begin
        r_shift <= '0;
        r_count <= '0;
      end
    end
  end

  // Idle-gap counter: only runs while collecting, cleared by every word, saturating
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_gap <= '0;
    end else if (r_state == HUNT || w_nextState == HUNT || bus.i_word_dv) begin
      r_gap <= '0;
    end else if (r_gap != GAP_W'(TIMEOUT_CYCLES)) begin
      r_gap <= r_gap + GAP_W'(1);
    end
  end

  assign bus.o_data = r_data;
  assign bus.o_dv   = r_dv;
  assign bus.o_busy = r_busy;
  assign bus.o_err  = r_err;

endmodule

// File: tb/tb_packet_assembler.sv
// Directed testbench for packet_assembler with a short timeout so that
// idle-gap behaviour can be exercised in a few dozen cycles.
module tb_packet_assembler;

  logic clk;
  logic i_reset;

  int checks;
  int errors;
  int dvCount;
  int errCount;
  int bothCount;
  int baseDv;
  int baseErr;

  packet_assembler_if #(.WORD_WIDTH(8), .VALUE_WORDS(4)) bus ();

  packet_assembler #(
    .WORD_WIDTH(8),
    .VALUE_WORDS(4),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk    (clk),
    .i_reset(i_reset),
    .bus    (bus)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge
  initial begin
    dvCount   = 0;
    errCount  = 0;
    bothCount = 0;
  end
  always @(negedge clk) begin
    if (bus.o_dv)              dvCount++;
    if (bus.o_err)             errCount++;
    if (bus.o_dv && bus.o_err) bothCount++;
  end

  // Drive one cycle of input at the falling edge, sampled at the next rising edge
  task automatic applyStimulus(input logic dv, input logic [7:0] word);
    @(negedge clk);
    bus.i_word_dv = dv;
    bus.i_word    = word;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    i_reset       = 1'b1;
    bus.i_word    = 8'h00;
    bus.i_word_dv = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("reset o_data", 64'(bus.o_data), 64'h0);
    checkOutput("reset o_dv",   64'(bus.o_dv),   64'h0);
    checkOutput("reset o_busy", 64'(bus.o_busy), 64'h0);
    checkOutput("reset o_err",  64'(bus.o_err),  64'h0);
    i_reset = 1'b0;
    idle(2);

    // Frame 77 05 DE AD BE EF, one word every 3 cycles
    baseDv  = dvCount;
    baseErr = errCount;
    applyStimulus(1'b1, 8'h77);
    applyStimulus(1'b0, 8'h00);
    checkOutput("busy after cmd", 64'(bus.o_busy), 64'h1);
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b1, 8'h05); idle(2);
    applyStimulus(1'b1, 8'hDE); idle(2);
    applyStimulus(1'b1, 8'hAD); idle(2);
    checkOutput("no partial o_data", 64'(bus.o_data), 64'h0);
    applyStimulus(1'b1, 8'hBE); idle(2);
    applyStimulus(1'b1, 8'hEF);
    applyStimulus(1'b0, 8'h00);
    checkOutput("slow frame o_dv",   64'(bus.o_dv),   64'h1);
    checkOutput("slow frame o_data", 64'(bus.o_data), 64'h7705DEADBEEF);
    checkOutput("slow frame busy",   64'(bus.o_busy), 64'h0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("o_dv one cycle", 64'(bus.o_dv), 64'h0);
    idle(2);
    checkOutput("slow frame dv count",  64'(dvCount - baseDv),   64'd1);
    checkOutput("slow frame err count", 64'(errCount - baseErr), 64'd0);

    // Bad command 41 followed by a read frame
    baseDv  = dvCount;
    baseErr = errCount;
    applyStimulus(1'b1, 8'h41);
    applyStimulus(1'b1, 8'h72);
    checkOutput("bad cmd o_err",  64'(bus.o_err),  64'h1);
    checkOutput("bad cmd busy",   64'(bus.o_busy), 64'h0);
    applyStimulus(1'b1, 8'h10);
    checkOutput("o_err one cycle", 64'(bus.o_err), 64'h0);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h2A);
    applyStimulus(1'b0, 8'h00);
    checkOutput("read frame o_dv",   64'(bus.o_dv),   64'h1);
    checkOutput("read frame o_data", 64'(bus.o_data), 64'h72100000002A);
    idle(3);
    checkOutput("read frame dv count",  64'(dvCount - baseDv),   64'd1);
    checkOutput("read frame err count", 64'(errCount - baseErr), 64'd1);

    // Timeout: 77 01 02 then 16 idle cycles
    baseDv  = dvCount;
    baseErr = errCount;
    applyStimulus(1'b1, 8'h77);
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b1, 8'h02);
    idle(16);
    checkOutput("gap 15 still busy", 64'(bus.o_busy), 64'h1);
    checkOutput("gap 15 no err",     64'(bus.o_err),  64'h0);
    applyStimulus(1'b0, 8'h00);
    checkOutput("timeout o_err",  64'(bus.o_err),  64'h1);
    checkOutput("timeout busy",   64'(bus.o_busy), 64'h0);
    checkOutput("timeout o_data", 64'(bus.o_data), 64'h72100000002A);
    applyStimulus(1'b1, 8'h72);
    applyStimulus(1'b1, 8'h03);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h04);
    applyStimulus(1'b0, 8'h00);
    checkOutput("post-timeout o_data", 64'(bus.o_data), 64'h720300000004);
    idle(3);
    checkOutput("timeout dv count",  64'(dvCount - baseDv),   64'd1);
    checkOutput("timeout err count", 64'(errCount - baseErr), 64'd1);

    // Gap of 15 idle cycles, next word on the 16th: no timeout
    baseDv  = dvCount;
    baseErr = errCount;
    applyStimulus(1'b1, 8'h77);
    applyStimulus(1'b1, 8'h01);
    idle(15);
    applyStimulus(1'b1, 8'h02);
    applyStimulus(1'b1, 8'h03);
    checkOutput("edge gap busy", 64'(bus.o_busy), 64'h1);
    checkOutput("edge gap err",  64'(bus.o_err),  64'h0);
    applyStimulus(1'b1, 8'h04);
    applyStimulus(1'b1, 8'h05);
    applyStimulus(1'b0, 8'h00);
    checkOutput("edge gap o_dv",   64'(bus.o_dv),   64'h1);
    checkOutput("edge gap o_data", 64'(bus.o_data), 64'h770102030405);
    idle(3);
    checkOutput("edge gap err count", 64'(errCount - baseErr), 64'd0);

    // Two frames back to back on 12 consecutive cycles
    baseDv  = dvCount;
    baseErr = errCount;
    applyStimulus(1'b1, 8'h72);
    applyStimulus(1'b1, 8'h11);
    applyStimulus(1'b1, 8'h22);
    applyStimulus(1'b1, 8'h33);
    applyStimulus(1'b1, 8'h44);
    applyStimulus(1'b1, 8'h55);
    applyStimulus(1'b1, 8'h77);
    checkOutput("b2b first o_dv",   64'(bus.o_dv),   64'h1);
    checkOutput("b2b first o_data", 64'(bus.o_data), 64'h721122334455);
    applyStimulus(1'b1, 8'h66);
    checkOutput("b2b second cmd busy", 64'(bus.o_busy), 64'h1);
    applyStimulus(1'b1, 8'h77);
    applyStimulus(1'b1, 8'h88);
    checkOutput("b2b mid o_dv", 64'(bus.o_dv), 64'h0);
    applyStimulus(1'b1, 8'h99);
    applyStimulus(1'b1, 8'hAA);
    applyStimulus(1'b0, 8'h00);
    checkOutput("b2b second o_dv",   64'(bus.o_dv),   64'h1);
    checkOutput("b2b second o_data", 64'(bus.o_data), 64'h7766778899AA);
    idle(3);
    checkOutput("b2b dv count",  64'(dvCount - baseDv),   64'd2);
    checkOutput("b2b err count", 64'(errCount - baseErr), 64'd0);

    // Asynchronous reset after three words, strobes during reset ignored
    baseDv  = dvCount;
    baseErr = errCount;
    applyStimulus(1'b1, 8'h72);
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b1, 8'h02);
    @(posedge clk);
    #2;
    i_reset = 1'b1;
    #1;
    checkOutput("async reset o_data", 64'(bus.o_data), 64'h0);
    checkOutput("async reset o_busy", 64'(bus.o_busy), 64'h0);
    checkOutput("async reset o_dv",   64'(bus.o_dv),   64'h0);
    checkOutput("async reset o_err",  64'(bus.o_err),  64'h0);
    applyStimulus(1'b1, 8'h77);
    applyStimulus(1'b1, 8'h03);
    applyStimulus(1'b0, 8'h00);
    checkOutput("strobe in reset busy", 64'(bus.o_busy), 64'h0);
    i_reset = 1'b0;
    applyStimulus(1'b1, 8'h77);
    applyStimulus(1'b1, 8'hAB);
    applyStimulus(1'b1, 8'hCD);
    applyStimulus(1'b1, 8'hEF);
    applyStimulus(1'b1, 8'h01);
    applyStimulus(1'b1, 8'h23);
    applyStimulus(1'b0, 8'h00);
    checkOutput("after reset o_dv",   64'(bus.o_dv),   64'h1);
    checkOutput("after reset o_data", 64'(bus.o_data), 64'h77ABCDEF0123);
    idle(3);
    checkOutput("reset section dv count",  64'(dvCount - baseDv),   64'd1);
    checkOutput("reset section err count", 64'(errCount - baseErr), 64'd0);
    checkOutput("dv and err overlap", 64'(bothCount), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/packet_assembler.md
PACKET_ASSEMBLER -- requirements
Module: packet_assembler

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 8, giving the width of one received word in bits.
REQ-002 The block SHALL have parameter VALUE_WORDS, default 4, giving the number of value words per frame.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 100000, giving the maximum idle gap in clk cycles allowed between words of one frame.
REQ-004 The block SHALL have one clock and asynchronous, active-high reset; port `clk`, input, 1 bit, the sole clock, all logic on its rising edge.
REQ-005 Port `i_reset`, input, 1 bit, asynchronous active-high reset.
REQ-006 Port `i_word`, input, WORD_WIDTH bits, received word, valid only when i_word_dv=1.
REQ-007 Port `i_word_dv`, input, 1 bit, one-cycle strobe qualifying i_word; each high cycle is one word.
REQ-008 Port `o_data`, output, (VALUE_WORDS+2)*WORD_WIDTH bits, last complete frame, command word in the top WORD_WIDTH bits, then address, then value words MSW first.
REQ-009 Port `o_dv`, output, 1 bit, one-cycle pulse marking a new o_data.
REQ-010 Port `o_busy`, output, 1 bit, high while a frame is partially collected.
REQ-011 Port `o_err`, output, 1 bit, one-cycle pulse on discarded input (bad command word or timeout).

Function
REQ-012 Frame format SHALL be C, A, V x VALUE_WORDS, one word each, in arrival order; FRAME_WORDS = VALUE_WORDS+2.
REQ-013 State machine SHALL have states HUNT and COLLECT; reset state HUNT.
REQ-014 In HUNT, a strobed word equal to 8'h72 ('r') or 8'h77 ('w') SHALL be loaded into the shift register as word 0, word count set to 1, state -> COLLECT.
REQ-015 In HUNT, any other strobed word SHALL be dropped, o_err pulsed high the next cycle, state remains HUNT.
REQ-016 In COLLECT, each strobed word SHALL be shifted in (earlier words move toward MSB) and the word count incremented.
REQ-017 When the strobed word is word FRAME_WORDS-1, on that same edge the full frame SHALL be copied to the o_data register, o_dv set high for exactly the next cycle, count cleared, state -> HUNT.
REQ-018 Latency: o_dv and new o_data SHALL appear one clk cycle after the edge sampling the final word.
REQ-019 o_data SHALL change only on frame completion (REQ-017) or reset; partial frames SHALL never be visible on o_data.
REQ-020 A command word strobed on the cycle immediately after frame completion SHALL be accepted (back-to-back frames, no dead cycle).
REQ-021 In COLLECT, a gap counter of width $clog2(TIMEOUT_CYCLES+1) SHALL clear on every accepted word and increment on every non-strobed cycle.
REQ-022 If the gap counter reaches TIMEOUT_CYCLES with no strobe, the partial frame SHALL be discarded, o_err pulsed the next cycle, count cleared, state -> HUNT.
REQ-023 A strobe on the same cycle the counter would reach TIMEOUT_CYCLES SHALL win: the word is accepted, no timeout.
REQ-024 The gap counter SHALL be held at 0 in HUNT and SHALL saturate, never wrap.
REQ-025 o_busy SHALL equal (state == COLLECT), registered.
REQ-026 o_dv and o_err SHALL never be high in the same cycle; each is high for at most one cycle per event.
REQ-027 Value words SHALL not be checked; any value (including 8'h72/8'h77) is accepted as A or V.

Reset
REQ-028 Asserting i_reset SHALL immediately (without a clk edge) force state HUNT, word count 0, gap counter 0, shift register 0, o_data 0, o_dv 0, o_busy 0, o_err 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame with no o_dv and no o_err; after release, the first accepted word is treated as a command in HUNT.
REQ-030 Strobes during reset SHALL be ignored.

Verification
REQ-031 Frame 77 05 DE AD BE EF, one word every 3 cycles -> one o_dv pulse 1 cycle after the EF strobe, o_data = 48'h7705DEADBEEF, o_err never high.
REQ-032 Words 41 72 10 00 00 00 2A -> o_err pulse after 41 only; o_data = 48'h72100000002A with one o_dv.
REQ-033 TIMEOUT_CYCLES=16, send 77 01 02 then wait 16 idle cycles -> o_err pulse, o_busy falls, no o_dv; then 72 03 00 00 00 04 -> o_data = 48'h720300000004.
REQ-034 TIMEOUT_CYCLES=16, gap of exactly 15 idle cycles with the next strobe on cycle 16 -> no timeout, frame completes normally.
REQ-035 Two frames strobed on 12 consecutive cycles -> two o_dv pulses 6 cycles apart, o_data matches each frame in turn.
REQ-036 Assert i_reset asynchronously after 3 words of a frame -> outputs 0 before the next clk edge; a full frame after release assembles correctly.
